// File: rtl/dice_cgra_tid_dispatcher_if.sv
// Descriptor intake and TID issue port between the block scheduler and the dispatcher.
// master drives descriptors and the stall; slave is the dispatcher driving disp_*.
interface dice_cgra_tid_dispatcher_if #(
  parameter int TID_W = 10
);
  logic             blk_valid;
  logic             blk_ready;
  logic [TID_W-1:0] blk_tid_start;
  logic [TID_W-1:0] blk_tid_count;
  logic             issue_stall;
  logic [TID_W-1:0] disp_tid;
  logic             disp_valid;

  modport master (
    output blk_valid, blk_tid_start, blk_tid_count, issue_stall,
    input  blk_ready, disp_tid, disp_valid
  );

  modport slave (
    input  blk_valid, blk_tid_start, blk_tid_count, issue_stall,
    output blk_ready, disp_tid, disp_valid
  );
endinterface

// File: rtl/dice_cgra_tid_dispatcher.sv
// Issues one TID per cycle for an accepted block, drains the CGRA+IO pipe, then pulses done.
// First issue one cycle after acceptance; issue_stall holds issue, blk_ready low while a block is live.
module dice_cgra_tid_dispatcher #(
  parameter int NUM_TID             = 512,
  parameter int MAX_CGRA_PIPE_STAGE = 32,
  parameter int MAX_IO_PIPE_STAGE   = 8,
  localparam int TID_W = $clog2(NUM_TID + 1),
  localparam int LAT_W = $clog2(MAX_CGRA_PIPE_STAGE + 2 * MAX_IO_PIPE_STAGE + 1),
  localparam int CL_W  = $clog2(MAX_CGRA_PIPE_STAGE + 1),
  localparam int IO_W  = $clog2(MAX_IO_PIPE_STAGE + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  dice_cgra_tid_dispatcher_if.slave         bus,
  input  logic [CL_W-1:0]                   cgra_compute_latency,
  input  logic [IO_W-1:0]                   io_latency_in_max,
  input  logic [IO_W-1:0]                   io_latency_out_max,
  output logic                              busy,
  output logic                              done,
  output logic                              range_err,
  output logic [TID_W-1:0]                  issued_count
);

  localparam logic [TID_W-1:0] NUM_T   = TID_W'(NUM_TID);
  localparam logic [TID_W-1:0] TID_ONE = TID_W'(1);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TID_W-1:0] cur_tid_q, cur_tid_d;
  logic [TID_W-1:0] eff_count_q, eff_count_d;
  logic [TID_W-1:0] issued_count_q, issued_count_d;
  logic [LAT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             err_q, err_d;
  logic             blk_ready_q, blk_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             range_err_q, range_err_d;

  logic [TID_W-1:0] room;
  logic [TID_W-1:0] clamp_count;
  logic [LAT_W-1:0] lat_sum;
  logic             accept;
  logic             last_issue;

  // Clamp so the block never runs past the last thread slot.
  always_comb begin
    room = NUM_T - bus.blk_tid_start;
    if (bus.blk_tid_start >= NUM_T) begin
      clamp_count = '0;
    end else if (bus.blk_tid_count < room) begin
      clamp_count = bus.blk_tid_count;
    end else begin
      clamp_count = room;
    end
    lat_sum = LAT_W'(cgra_compute_latency) + LAT_W'(io_latency_in_max)
            + LAT_W'(io_latency_out_max);
    accept     = (state_q == S_IDLE) && bus.blk_valid && blk_ready_q;
    last_issue = (issued_count_q == (eff_count_q - TID_ONE));
  end

  always_comb begin
    state_d        = state_q;
    cur_tid_d      = cur_tid_q;
    eff_count_d    = eff_count_q;
    issued_count_d = issued_count_q;
    drain_cnt_d    = drain_cnt_q;
    err_d          = err_q;
    blk_ready_d    = blk_ready_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    range_err_d    = 1'b0;

    if (clr) begin
      state_d        = S_IDLE;
      cur_tid_d      = '0;
      eff_count_d    = '0;
      issued_count_d = '0;
      drain_cnt_d    = '0;
      err_d          = 1'b0;
      blk_ready_d    = 1'b1;
      busy_d         = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cur_tid_d      = bus.blk_tid_start;
            eff_count_d    = clamp_count;
            issued_count_d = '0;
            // Latencies are captured here so later changes cannot disturb this block.
            drain_cnt_d    = lat_sum;
            err_d          = (clamp_count != bus.blk_tid_count);
            blk_ready_d    = 1'b0;
            if (clamp_count == '0) begin
              state_d     = S_DONE;
              done_d      = 1'b1;
              range_err_d = (clamp_count != bus.blk_tid_count);
              busy_d      = 1'b0;
            end else begin
              state_d = S_ISSUE;
              busy_d  = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (!bus.issue_stall) begin
            issued_count_d = issued_count_q + TID_ONE;
            // Hold cur_tid on the final issue so disp_tid never shows NUM_TID.
            if (last_issue) begin
              state_d = S_DRAIN;
            end else begin
              cur_tid_d = cur_tid_q + TID_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            range_err_d = err_q;
            busy_d      = 1'b0;
          end else begin
            drain_cnt_d = drain_cnt_q - LAT_ONE;
          end
        end
        S_DONE: begin
          state_d     = S_IDLE;
          blk_ready_d = 1'b1;
        end
        default: begin
          state_d     = S_IDLE;
          blk_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cur_tid_q      <= '0;
      eff_count_q    <= '0;
      issued_count_q <= '0;
      drain_cnt_q    <= '0;
      err_q          <= 1'b0;
      blk_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      range_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_tid_q      <= cur_tid_d;
      eff_count_q    <= eff_count_d;
      issued_count_q <= issued_count_d;
      drain_cnt_q    <= drain_cnt_d;
      err_q          <= err_d;
      blk_ready_q    <= blk_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      range_err_q    <= range_err_d;
    end
  end

  assign bus.blk_ready  = blk_ready_q;
  assign bus.disp_tid   = cur_tid_q;
  assign bus.disp_valid = (state_q == S_ISSUE) && !bus.issue_stall;
  assign busy           = busy_q;
  assign done           = done_q;
  assign range_err      = range_err_q;
  assign issued_count   = issued_count_q;

  a_tid_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    bus.disp_valid |-> (bus.disp_tid < NUM_T));
  a_err_with_done : assert property (@(posedge clk) disable iff (!rst_n)
    range_err |-> done);

endmodule

// File: tb/tb_dice_cgra_tid_dispatcher.sv
// Directed bench for dice_cgra_tid_dispatcher; expected issues and done pulses are
// queued by the stimulus and consumed by an independent output monitor.
module tb_dice_cgra_tid_dispatcher;
  localparam int TID_W = 10;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [5:0] cgra_compute_latency;
  logic [3:0] io_latency_in_max;
  logic [3:0] io_latency_out_max;
  logic       busy;
  logic       done;
  logic       range_err;
  logic [TID_W-1:0] issued_count;

  dice_cgra_tid_dispatcher_if #(.TID_W(TID_W)) bus ();

  dice_cgra_tid_dispatcher dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .clr                  (clr),
    .bus                  (bus),
    .cgra_compute_latency (cgra_compute_latency),
    .io_latency_in_max    (io_latency_in_max),
    .io_latency_out_max   (io_latency_out_max),
    .busy                 (busy),
    .done                 (done),
    .range_err            (range_err),
    .issued_count         (issued_count)
  );

  typedef struct {
    bit is_done;
    int tid;
    int cyc;
    bit err;
    int ic;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input int tid, input int c);
    exp_t e;
    e.is_done = 1'b0; e.tid = tid; e.cyc = c; e.err = 1'b0; e.ic = 0;
    q.push_back(e);
  endtask

  task automatic push_done(input int c, input bit err, input int ic);
    exp_t e;
    e.is_done = 1'b1; e.tid = 0; e.cyc = c; e.err = err; e.ic = ic;
    q.push_back(e);
  endtask

  // Waits for blk_ready, then presents a descriptor for this cycle; returns its cycle.
  task automatic present(input int start, input int count, input int lc, input int li,
                         input int lo, output int t);
    int n;
    n = 0;
    while (!bus.blk_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.blk_ready) chk("blk_ready_timeout", 0, 1);
    bus.blk_tid_start    = TID_W'(start);
    bus.blk_tid_count    = TID_W'(count);
    cgra_compute_latency = 6'(lc);
    io_latency_in_max    = 4'(li);
    io_latency_out_max   = 4'(lo);
    bus.blk_valid        = 1'b1;
    t = cyc;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      chk("scoreboard_drain_timeout", q.size(), 0);
      q.delete();
    end
    step();
  endtask

  // Output monitor: every disp_valid or done must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.disp_valid) begin
        if (q.size() == 0 || q[0].is_done) begin
          chk("unexpected_disp_tid", int'(bus.disp_tid), -1);
        end else begin
          e = q.pop_front();
          chk("disp_tid", int'(bus.disp_tid), e.tid);
          chk("disp_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (q.size() == 0 || !q[0].is_done) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("range_err", int'(range_err), int'(e.err));
          chk("done_issued_count", int'(issued_count), e.ic);
          chk("done_busy", int'(busy), 0);
          chk("done_blk_ready", int'(bus.blk_ready), 0);
        end
      end
      if (range_err && !done) chk("range_err_without_done", 1, 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: cycle %0d, still running, required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int n;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_tid_start = '0;
    bus.blk_tid_count = '0;
    bus.issue_stall = 1'b0;
    cgra_compute_latency = '0;
    io_latency_in_max = '0;
    io_latency_out_max = '0;
    repeat (3) step();

    chk("rst_blk_ready", int'(bus.blk_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_disp_valid", int'(bus.disp_valid), 0);
    chk("rst_disp_tid", int'(bus.disp_tid), 0);
    chk("rst_issued_count", int'(issued_count), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    step();

    // 1: plain block, total latency 5.
    present(0, 4, 3, 1, 1, t);
    for (int i = 0; i < 4; i++) push_disp(i, t + 1 + i);
    push_done(t + 11, 1'b0, 4);
    step();
    bus.blk_valid = 1'b0;
    chk("t1_busy_in_issue", int'(busy), 1);
    chk("t1_ready_in_issue", int'(bus.blk_ready), 0);
    wait_empty();

    // 2: two stalled cycles on the second issue, total latency 6.
    present(10, 3, 2, 2, 2, t);
    push_disp(10, t + 1);
    push_disp(11, t + 4);
    push_disp(12, t + 5);
    push_done(t + 13, 1'b0, 3);
    step();
    bus.blk_valid = 1'b0;
    step();
    bus.issue_stall = 1'b1;
    step();
    step();
    bus.issue_stall = 1'b0;
    wait_empty();

    // 3: descriptor runs past the last slot and is clamped to two TIDs.
    present(510, 8, 0, 0, 0, t);
    push_disp(510, t + 1);
    push_disp(511, t + 2);
    push_done(t + 4, 1'b1, 2);
    step();
    bus.blk_valid = 1'b0;
    step();
    step();
    bus.issue_stall = 1'b1;   // lands in DRAIN and must have no effect
    step();
    bus.issue_stall = 1'b0;
    wait_empty();

    // 4: empty block goes straight to done.
    present(5, 0, 7, 7, 7, t);
    push_done(t + 1, 1'b0, 0);
    step();
    bus.blk_valid = 1'b0;
    chk("t4_ready_in_done", int'(bus.blk_ready), 0);
    step();
    chk("t4_ready_after_done", int'(bus.blk_ready), 1);
    wait_empty();

    // 4b: start beyond the last slot clamps to zero threads and flags the error.
    present(512, 3, 1, 1, 1, t);
    push_done(t + 1, 1'b1, 0);
    step();
    bus.blk_valid = 1'b0;
    wait_empty();

    // 5: clear during the second issue cycle drops the block without done.
    present(20, 10, 1, 1, 1, t);
    push_disp(20, t + 1);
    push_disp(21, t + 2);
    step();
    bus.blk_valid = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_disp_valid_after_clr", int'(bus.disp_valid), 0);
    chk("t5_ready_after_clr", int'(bus.blk_ready), 1);
    chk("t5_issued_count_after_clr", int'(issued_count), 0);
    chk("t5_busy_after_clr", int'(busy), 0);
    repeat (20) step();
    chk("t5_scoreboard_empty", q.size(), 0);

    // 5b: clear coincident with a descriptor wins; nothing is accepted.
    bus.blk_tid_start = 10'd1;
    bus.blk_tid_count = 10'd1;
    bus.blk_valid = 1'b1;
    clr = 1'b1;
    step();
    bus.blk_valid = 1'b0;
    clr = 1'b0;
    chk("t5b_busy_after_clr_accept", int'(busy), 0);
    repeat (5) step();

    // 6: second descriptor held through the first block; latency change only affects it.
    present(0, 2, 2, 1, 1, t);
    push_disp(0, t + 1);
    push_disp(1, t + 2);
    push_done(t + 8, 1'b0, 2);
    push_disp(100, t + 10);
    push_done(t + 26, 1'b0, 1);
    step();
    bus.blk_tid_start = 10'd100;
    bus.blk_tid_count = 10'd1;
    cgra_compute_latency = 6'd10;
    io_latency_in_max = 4'd2;
    io_latency_out_max = 4'd2;
    n = 0;
    while (!bus.blk_ready && n < 100) begin
      step();
      n++;
    end
    chk("t6_second_accept_cycle", cyc, t + 9);
    step();
    bus.blk_valid = 1'b0;
    wait_empty();

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dice_cgra_tid_dispatcher.md
Name: dice_cgra_tid_dispatcher

Overview:
Sequences thread IDs into the CGRA subsystem for one kernel block. It accepts a block descriptor (start TID, thread count), issues one TID per cycle on disp_tid/disp_valid with stall support, then drains the CGRA plus I/O pipeline. It pulses done once the last thread's results are written back, so the next block or config can be loaded. It sits between the block scheduler/metadata loader and the subsystem's disp_tid/disp_valid inputs.

Parameters:
NUM_TID, 512, number of thread slots (RF depth); TID_W = $clog2(NUM_TID+1)
MAX_CGRA_PIPE_STAGE, 32, maximum CGRA compute latency
MAX_IO_PIPE_STAGE, 8, maximum per-side I/O pipe latency; LAT_W = $clog2(MAX_CGRA_PIPE_STAGE+2*MAX_IO_PIPE_STAGE+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous abort/clear
blk_valid  in  1  block descriptor valid
blk_ready  out  1  dispatcher can accept a descriptor
blk_tid_start  in  TID_W  first TID of block
blk_tid_count  in  TID_W  number of threads (0..NUM_TID)
cgra_compute_latency  in  $clog2(MAX_CGRA_PIPE_STAGE+1)  CGRA pipe depth
io_latency_in_max  in  $clog2(MAX_IO_PIPE_STAGE+1)  worst-case input port latency
io_latency_out_max  in  $clog2(MAX_IO_PIPE_STAGE+1)  worst-case output port latency
issue_stall  in  1  hold issue this cycle
disp_tid  out  TID_W  TID being issued
disp_valid  out  1  TID issued this cycle
busy  out  1  block in progress (ISSUE or DRAIN)
done  out  1  one-cycle pulse when block fully retired
range_err  out  1  one-cycle pulse with done if the descriptor was clamped
issued_count  out  TID_W  TIDs issued so far in the current block

Behaviour:
- Reset (rst_n low, async) and clr (sync, highest priority): state IDLE. All outputs 0 except blk_ready=1. Any in-flight block is dropped with no done.
- FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: blk_ready=1. Acceptance = blk_valid & blk_ready in cycle T. At acceptance, latch:
  - cur_tid = blk_tid_start
  - eff_count = min(blk_tid_count, NUM_TID - blk_tid_start); eff_count = 0 if blk_tid_start >= NUM_TID
  - total_lat = cgra_compute_latency + io_latency_in_max + io_latency_out_max, in LAT_W bits with no overflow
  - err flag = (eff_count != blk_tid_count)
- Latency inputs are sampled only at acceptance. Later changes have no effect on the current block.
- Acceptance with eff_count = 0 goes straight to DONE, with no disp_valid.
- ISSUE: disp_tid = cur_tid (registered). disp_valid = !issue_stall (combinational on the stall only).
  - Each non-stalled cycle: cur_tid++, issued_count++.
  - The cycle that issues the eff_count-th TID (cycle L) moves to DRAIN. The drain counter is loaded with total_lat.
  - First possible issue is cycle T+1. disp_tid never reaches NUM_TID.
- DRAIN: disp_valid=0, busy=1. The counter decrements each cycle. When the counter is 0, move to DONE. The done pulse is therefore in cycle L+total_lat+2.
- DONE: one cycle. done=1, range_err=err, busy=0, blk_ready=0. Next cycle IDLE with blk_ready=1, and issued_count keeps its value until the next acceptance, where it resets to 0.
- blk_ready=0 in ISSUE, DRAIN and DONE. Descriptors presented then are not accepted, and the sender must hold them.
- issue_stall is ignored outside ISSUE. A stall on the would-be last issue keeps the FSM in ISSUE.
- clr in the same cycle as blk_valid: clr wins, nothing is accepted.

Test Plan:
1. Reset, then start=0, count=4, latencies 3/1/1, no stall -> disp_tid 0,1,2,3 on cycles T+1..T+4, total_lat=5, done at T+4+5+2=T+11, issued_count=4.
2. start=10, count=3, issue_stall high on the 2nd issue cycle for 2 cycles -> disp_tid 10 at T+1, 11 at T+4, 12 at T+5; done at T+5+total_lat+2.
3. start=510, count=8, NUM_TID=512 -> only TIDs 510 and 511 issued; done pulse with range_err=1.
4. count=0 -> no disp_valid; done at T+1; blk_ready back high at T+2.
5. clr asserted mid-ISSUE after 2 issues -> disp_valid=0 next cycle, no done, blk_ready=1, issued_count=0.
6. blk_valid held high during DRAIN with a second descriptor, and latency inputs changed after acceptance -> second descriptor accepted only in the cycle after done; first block's done timing uses the originally sampled latencies.
